// File: rtl/eq_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : eq_i2s_tx                                                        |
// | Purpose : Sample FIFO plus I2S transmitter with internally generated       |
// |           BCLK/LRCLK; each mono sample goes out on both channels.          |
// |           Define EQ_I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module eq_i2s_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          enable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata
);

  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W  = c_PTR_W + 1;
  localparam int c_DIV_W  = $clog2(BCLK_DIV);
  localparam int c_SLOT_W = $clog2(2 * DATA_W);
  localparam int c_IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_RISE  = c_DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(2 * DATA_W - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_HALF = c_SLOT_W'(DATA_W);
  localparam logic [c_SLOT_W-1:0] c_SLOT_MSB  = c_SLOT_W'(DATA_W - 1);
  localparam logic [c_LVL_W-1:0]  c_FULL      = c_LVL_W'(FIFO_DEPTH);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_SLOT_W-1:0] r_slot;
  logic [c_SLOT_W-1:0] w_slot_nxt;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   w_word_nxt;
  logic [c_IDX_W-1:0]  w_bit_idx;
  logic                w_lr_nxt;
  logic                w_sd_nxt;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_LVL_W-1:0]  r_count;
  logic [c_LVL_W-1:0]  w_count_nxt;
  logic                r_in_ready;

  logic                r_bclk;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_underrun;

  logic w_run;
  logic w_rise_evt;
  logic w_fall_evt;
  logic w_frame_end;
  logic w_frame_start;
  logic w_stop;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (enable) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  if (w_stop) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    w_run         = (r_state == c_ST_RUN);
    w_rise_evt    = w_run && (r_div_cnt == c_DIV_RISE);
    w_fall_evt    = w_run && (r_div_cnt == c_DIV_LAST);
    w_frame_end   = w_fall_evt && (r_slot == c_SLOT_LAST);
    w_frame_start = w_frame_end && enable;
    w_stop        = w_frame_end && !enable;
  end

  // ---------------- FIFO control ----------------
  always_comb begin
    w_empty     = (r_count == '0);
    w_push      = in_valid && r_in_ready;
    w_pop       = w_frame_start && !w_empty;
    w_count_nxt = r_count + c_LVL_W'(w_push) - c_LVL_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // Ready is derived from the post-update level, so it reflects occupancy
  // before any pop on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != c_FULL);
    end
  end

  // ---------------- slot data selection ----------------
  always_comb begin
    w_slot_nxt = (r_slot == c_SLOT_LAST) ? '0 : r_slot + 1'b1;
    w_word_nxt = r_word;
    if (w_frame_start) w_word_nxt = w_empty ? '0 : r_mem[r_rd_ptr];
    // Both channel slots replay the same word MSB first.
    w_bit_idx = (w_slot_nxt < c_SLOT_HALF) ? c_IDX_W'(c_SLOT_MSB - w_slot_nxt)
                                           : c_IDX_W'(c_SLOT_LAST - w_slot_nxt);
    w_sd_nxt  = w_word_nxt[w_bit_idx];
`ifdef EQ_I2S_TX_LEFT_JUSTIFIED_EN
    w_lr_nxt  = (w_slot_nxt >= c_SLOT_HALF);
`else
    w_lr_nxt  = (w_slot_nxt >= c_SLOT_MSB) && (w_slot_nxt != c_SLOT_LAST);
`endif
  end

  // ---------------- bit clock and serial datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_slot     <= '0;
      r_word     <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!w_run) begin
      r_div_cnt  <= '0;
      r_slot     <= c_SLOT_LAST;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_div_cnt  <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      if (w_rise_evt) r_bclk <= 1'b1;
      if (w_fall_evt) begin
        r_bclk <= 1'b0;
        r_slot <= w_slot_nxt;
        if (w_stop) begin
          r_lrclk <= 1'b0;
          r_sdata <= 1'b0;
        end else begin
          r_lrclk    <= w_lr_nxt;
          r_sdata    <= w_sd_nxt;
          r_word     <= w_word_nxt;
          r_underrun <= w_frame_start && w_empty;
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign fifo_level = r_count;
  assign underrun   = r_underrun;
  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_sdata  = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_eq_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_eq_i2s_tx                                                     |
// | Purpose : Directed bench for eq_i2s_tx with a frame-level reference model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_eq_i2s_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;
  localparam int SLOTS = 2 * DW;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          enable;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;

  int n_checks = 0;
  int n_err    = 0;
  int urun_cnt = 0;

  eq_i2s_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .BCLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .enable     (enable),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time since RUN entry in clk cycles plus a sample queue.
  bit            m_run;
  int            m_k;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_word;
  bit            m_urun;
  bit            m_acc;

  function automatic int m_slot();
    return (m_k / DIV - 1) % SLOTS;
  endfunction

  function automatic int m_frame();
    return (m_k / DIV - 1) / SLOTS;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  = 1'b0;
      m_k    = 0;
      m_q.delete();
      m_word = '0;
      m_urun = 1'b0;
    end else begin
      m_acc  = in_valid && (m_q.size() < DEPTH);
      m_urun = 1'b0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1'b1;
          m_k   = 0;
        end
      end else begin
        m_k++;
        if ((m_k % DIV) == 0 && m_slot() == 0) begin
          if (!enable) begin
            m_run = 1'b0;
            m_k   = 0;
          end else if (m_q.size() == 0) begin
            m_word = '0;
            m_urun = 1'b1;
          end else begin
            m_word = m_q.pop_front();
          end
        end
      end
      if (m_acc) m_q.push_back(in_data);
    end
  end

  function automatic logic [LW+4:0] model_out();
    logic b, l, d;
    int   s;
    b = m_run && ((m_k % DIV) >= DIV / 2);
    l = 1'b0;
    d = 1'b0;
    if (m_run && m_k >= DIV) begin
      s = m_slot();
`ifdef EQ_I2S_TX_LEFT_JUSTIFIED_EN
      l = (s >= DW);
`else
      l = (s >= DW - 1) && (s <= 2 * DW - 2);
`endif
      d = m_word[DW - 1 - (s % DW)];
    end
    return {b, l, d, m_urun, (m_q.size() < DEPTH), LW'(m_q.size())};
  endfunction

  always @(negedge clk) begin
    logic [LW+4:0] exp_v, act_v;
    if (!rst) begin
      exp_v = model_out();
      act_v = {i2s_bclk, i2s_lrclk, i2s_sdata, underrun, in_ready, fifo_level};
      n_checks++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t {bclk,lr,sd,urun,rdy,lvl} got=%b want=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  always @(negedge clk) if (underrun === 1'b1) urun_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic wait_rise();
    logic prev;
    prev = i2s_bclk;
    for (int n = 0; n < 3 * DIV; n++) begin
      @(negedge clk);
      if (!prev && i2s_bclk) return;
      prev = i2s_bclk;
    end
    timeout_fail("wait_bclk_rise");
  endtask

  task automatic capture_frame(output logic [15:0] w0, output logic [15:0] w1,
                               output logic [31:0] lr);
    w0 = '0; w1 = '0; lr = '0;
    for (int s = 0; s < SLOTS; s++) begin
      wait_rise();
      if (s < DW) w0 = {w0[14:0], i2s_sdata};
      else        w1 = {w1[14:0], i2s_sdata};
      lr[s] = i2s_lrclk;
    end
  endtask

  task automatic wait_slot(input int frame, input int slot);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (m_run && m_k >= DIV && m_frame() == frame && m_slot() == slot &&
          (m_k % DIV) >= DIV / 2) return;
    end
    timeout_fail("wait_slot");
  endtask

`ifdef EQ_I2S_TX_LEFT_JUSTIFIED_EN
  localparam logic [31:0] LR_PATTERN = 32'hFFFF_0000;
`else
  localparam logic [31:0] LR_PATTERN = 32'h7FFF_8000;
`endif

  initial begin
    logic [15:0] w0, w1;
    logic [31:0] lr;
    int n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bclk", {31'd0, i2s_bclk}, 0);
    check("rst_lrclk", {31'd0, i2s_lrclk}, 0);
    check("rst_sdata", {31'd0, i2s_sdata}, 0);
    check("rst_underrun", {31'd0, underrun}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_level", 32'(fifo_level), 0);
    repeat (8) @(negedge clk);

    // Single sample, then an underrun frame.
    in_valid = 1'b1; in_data = 16'hA5C3;
    @(negedge clk);
    in_valid = 1'b0; enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i2s_bclk && n < 10);
    check("first_bclk_rise", n, 3);
    capture_frame(w0, w1, lr);
    check("frame0_left", 32'(w0), 32'h0000_A5C3);
    check("frame0_right", 32'(w1), 32'h0000_A5C3);
    check("frame0_lrclk", lr, LR_PATTERN);
    urun_cnt = 0;
    capture_frame(w0, w1, lr);
    check("frame1_left", 32'(w0), 0);
    check("frame1_right", 32'(w1), 0);
    check("frame1_urun_cnt", urun_cnt, 1);

    // Write into the empty FIFO exactly on the frame-start edge.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    check("edge_write_underrun", {31'd0, underrun}, 1);
    check("edge_write_level", 32'(fifo_level), 1);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    check("stop_level", 32'(fifo_level), 1);
    check("stop_bclk", {31'd0, i2s_bclk}, 0);

    // Asynchronous reset in the middle of a right-channel bit.
    enable = 1'b1;
    wait_slot(0, 19);
    check("pre_rst_bclk", {31'd0, i2s_bclk}, 1);
    check("pre_rst_lrclk", {31'd0, i2s_lrclk}, 1);
    check("pre_rst_sdata", {31'd0, i2s_sdata}, 1);
    rst = 1'b1;
    #1;
    check("async_rst_bclk", {31'd0, i2s_bclk}, 0);
    check("async_rst_lrclk", {31'd0, i2s_lrclk}, 0);
    check("async_rst_sdata", {31'd0, i2s_sdata}, 0);
    check("async_rst_underrun", {31'd0, underrun}, 0);
    check("async_rst_in_ready", {31'd0, in_ready}, 1);
    check("async_rst_level", 32'(fifo_level), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Fill to full with the stream stopped, hold a ninth sample.
    for (int v = 1; v <= DEPTH; v++) begin
      in_valid = 1'b1; in_data = DW'(v);
      @(negedge clk);
    end
    in_data = 16'd9;
    check("full_level", 32'(fifo_level), 8);
    check("full_in_ready", {31'd0, in_ready}, 0);
    repeat (5) @(negedge clk);
    check("full_hold_level", 32'(fifo_level), 8);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 20);
    check("ready_after_pop", n, 5);
    check("pop_cycle_level", 32'(fifo_level), 7);
    @(negedge clk);
    in_valid = 1'b0;
    check("refill_level", 32'(fifo_level), 8);
    capture_frame(w0, w1, lr);
    check("fill_frame0_left", 32'(w0), 1);

    // Stop mid-frame; the frame completes and no further pops happen.
    wait_slot(2, 10);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    check("midstop_level", 32'(fifo_level), 6);
    check("midstop_bclk", {31'd0, i2s_bclk}, 0);

    // Drain remaining samples 4..9 plus one underrun frame.
    enable = 1'b1;
    repeat (7 * SLOTS * DIV + 10) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    check("drain_level", 32'(fifo_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
